memory_stage: RTL and testbench

- Memory stage of the sequential Y86-64 processor. It sits between execute and writeback.
- Consumes execute's valE along with valA, valP and icode. Performs the data-memory read or write for rmmovq, mrmovq, call, ret, pushq and popq against an internal byte-addressed little-endian data memory.
- Returns valM plus a done/error handshake to the processor control.
- Models a slow data memory through a configurable wait-state counter.

---
 rtl/memory_stage.sv | 139 +++++++++++++
 tb/tb_memory_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 memory stage with byte-addressed data memory and wait states
module memory_stage #(
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic        dmem_error
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        FINISH
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            wr_q;
    logic [AW-1:0]   addr_q;
    logic [63:0]     wdata_q;
    logic [63:0]     rd_data;
    logic            is_rd;
    logic            is_wr;
    logic [63:0]     req_addr;
    logic [63:0]     req_data;
    logic            fault;
    logic            go_access;
    logic            access_end;
    logic            accept;
    logic [7:0]      mem [MEM_BYTES];

    // Decode the incoming instruction into direction, address and store data
    always_comb begin
        is_rd    = 1'b0;
        is_wr    = 1'b0;
        req_addr = valE;
        req_data = valA;
        case (icode)
            4'h4:    is_wr = 1'b1;
            4'h5:    is_rd = 1'b1;
            4'h8:    begin is_wr = 1'b1; req_data = valP; end
            4'h9:    begin is_rd = 1'b1; req_addr = valA; end
            4'hA:    is_wr = 1'b1;
            4'hB:    begin is_rd = 1'b1; req_addr = valA; end
            default: ;
        endcase
    end

    // Full 64-bit compare so huge addresses cannot wrap into range
    assign fault      = (is_rd || is_wr) && (req_addr > MAX_ADDR);
    assign go_access  = (is_rd || is_wr) && !fault;
    assign access_end = (state == ACCESS) && (cnt == '0);

    // Next state and handshake; a start in the done cycle is accepted
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
                if (start) state_nx = go_access ? ACCESS : FINISH;
            end
            ACCESS: begin
                if (cnt == '0) begin
                    done     = 1'b1;
                    accept   = start;
                    state_nx = start ? (go_access ? ACCESS : FINISH) : IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            FINISH: begin
                done     = 1'b1;
                accept   = start;
                state_nx = start ? (go_access ? ACCESS : FINISH) : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Request latch, wait counter, fault flag and registered read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            valM       <= '0;
            dmem_error <= 1'b0;
        end else begin
            if (access_end && !wr_q) valM <= rd_data;
            if (accept) begin
                dmem_error <= fault;
                wr_q       <= is_wr;
                addr_q     <= req_addr[AW-1:0];
                wdata_q    <= req_data;
                cnt        <= CW'(WAIT_CYCLES);
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Little-endian 8-byte read from the latched address
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < 8; i++) rd_data[8*i +: 8] = mem[addr_q + AW'(i)];
    end

    // Memory write at the end of the access; reset in that cycle suppresses it
    always_ff @(posedge clk) begin
        if (rst_n && access_end && wr_q) begin
            for (int i = 0; i < 8; i++) mem[addr_q + AW'(i)] <= wdata_q[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard bench for memory_stage with 2 and 0 wait states
module tb_memory_stage;

    typedef struct {
        int          cyc;
        logic        err;
        logic [63:0] valm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode;
    logic [63:0] valE, valA, valP;
    logic        start [2];
    logic        busy  [2];
    logic        done  [2];
    logic [63:0] valM  [2];
    logic        dmem_error [2];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [63:0] lastv [2];
    logic        vchk  [2];
    logic [63:0] vexp  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_stage #(.MEM_BYTES(1024), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .icode(icode),
        .valE(valE), .valA(valA), .valP(valP),
        .busy(busy[0]), .done(done[0]), .valM(valM[0]), .dmem_error(dmem_error[0])
    );

    memory_stage #(.MEM_BYTES(1024), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .icode(icode),
        .valE(valE), .valA(valA), .valP(valP),
        .busy(busy[1]), .done(done[1]), .valM(valM[1]), .dmem_error(dmem_error[1])
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Monitor: valM is checked the cycle after done, since it registers at the done edge
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (vchk[d]) begin
                chk($sformatf("valm_d%0d", d), valM[d], vexp[d]);
                vchk[d] = 1'b0;
            end
            if (done[d] === 1'b1) begin
                if (qsize(d) == 0) begin
                    chk($sformatf("unexpected_done_d%0d", d), 64'd1, 64'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("done_cycle_d%0d", d), 64'(cyc), 64'(e.cyc));
                    chk($sformatf("dmem_error_d%0d", d), 64'(dmem_error[d]), 64'(e.err));
                    vchk[d] = 1'b1;
                    vexp[d] = e.valm;
                end
            end
        end
    end

    task automatic issue(input int d, input logic [3:0] ic, input logic [63:0] e,
                         input logic [63:0] a, input logic [63:0] p, input logic err,
                         input logic rd, input logic [63:0] rv, output int lat);
        exp_t x;
        int   w;
        w   = (d == 0) ? 2 : 0;
        lat = ((ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) && !err) ? w + 1 : 1;
        if (rd) lastv[d] = rv;
        x.cyc  = cyc + lat;
        x.err  = err;
        x.valm = lastv[d];
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
        icode = ic; valE = e; valA = a; valP = p;
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
    endtask

    task automatic op(input int d, input logic [3:0] ic, input logic [63:0] e,
                      input logic [63:0] a, input logic [63:0] p, input logic err,
                      input logic rd, input logic [63:0] rv);
        int lat;
        issue(d, ic, e, a, p, err, rd, rv, lat);
        repeat (lat) @(posedge clk);
        #1;
    endtask

    task automatic suite(input int d);
        int lat;
        op(d, 4'h4, 64'h10, 64'h1122334455667788, 64'h0, 1'b0, 1'b0, 64'h0);
        op(d, 4'h4, 64'h18, 64'h00000000000000AB, 64'h0, 1'b0, 1'b0, 64'h0);
        op(d, 4'h5, 64'h10, 64'h0, 64'h0, 1'b0, 1'b1, 64'h1122334455667788);
        op(d, 4'h5, 64'h11, 64'h0, 64'h0, 1'b0, 1'b1, 64'hAB11223344556677);
        op(d, 4'h8, 64'h3F8, 64'h0, 64'h2A, 1'b0, 1'b0, 64'h0);
        op(d, 4'h9, 64'h0, 64'h3F8, 64'h0, 1'b0, 1'b1, 64'h2A);
        op(d, 4'hA, 64'h3F9, 64'h77, 64'h0, 1'b1, 1'b0, 64'h0);
        op(d, 4'hB, 64'h0, 64'h3F8, 64'h0, 1'b0, 1'b1, 64'h2A);
        op(d, 4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0);
        op(d, 4'h6, 64'h10, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
        op(d, 4'hB, 64'h0, 64'h10, 64'h0, 1'b0, 1'b1, 64'h1122334455667788);
        op(d, 4'h4, 64'h20, 64'hCAFEF00D12345678, 64'h0, 1'b0, 1'b0, 64'h0);
        // second start during a pending access must be ignored
        if (d == 0) begin
            issue(d, 4'h4, 64'h30, 64'h0102030405060708, 64'h0, 1'b0, 1'b0, 64'h0, lat);
            chk("busy_during_access", 64'(busy[d]), 64'd1);
            icode = 4'h4; valE = 64'h40; valA = 64'hFFFF;
            start[d] = 1'b1;
            @(posedge clk); #1;
            start[d] = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            op(d, 4'h5, 64'h30, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0102030405060708);
        end
        // back-to-back: next start in the done cycle reads the just-written data
        issue(d, 4'h4, 64'h48, 64'h55AA55AA00FF00FF, 64'h0, 1'b0, 1'b0, 64'h0, lat);
        repeat (lat - 1) @(posedge clk);
        #1;
        op(d, 4'h5, 64'h48, 64'h0, 64'h0, 1'b0, 1'b1, 64'h55AA55AA00FF00FF);
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        icode = 4'h0; valE = '0; valA = '0; valP = '0;
        lastv[0] = '0; lastv[1] = '0;
        vchk[0] = 1'b0; vchk[1] = 1'b0;
        vexp[0] = '0; vexp[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_busy_d%0d", d), 64'(busy[d]), 64'd0);
            chk($sformatf("rst_done_d%0d", d), 64'(done[d]), 64'd0);
            chk($sformatf("rst_valm_d%0d", d), valM[d], 64'd0);
            chk($sformatf("rst_err_d%0d", d), 64'(dmem_error[d]), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        suite(0);
        suite(1);

        // reset one cycle into a pending write aborts it without done
        icode = 4'h4; valE = 64'h20; valA = 64'h5;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        lastv[0] = '0; lastv[1] = '0;
        chk("abort_busy", 64'(busy[0]), 64'd0);
        chk("abort_valm", valM[0], 64'd0);
        repeat (4) @(posedge clk);
        #1;
        op(0, 4'h5, 64'h20, 64'h0, 64'h0, 1'b0, 1'b1, 64'hCAFEF00D12345678);

        waited = 0;
        while ((q0.size() != 0 || q1.size() != 0) && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (q0.size() != 0 || q1.size() != 0)
            chk("drain_pending", 64'(q0.size() + q1.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
